fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
// - Shares the single framebuffer write port between two pixel requesters (round-robin) and an
//   optional clear sequencer that fills every pixel with one colour.
// - Sits between drawing logic and the framebuffer write side; all outputs are registered and drive
//   the framebuffer's write-clock domain directly (clk here = framebuffer write clock).
// PARAMETERS
// - FRAME_WIDTH     640  visible width in pixels
// - FRAME_HEIGHT    480  visible height in pixels
// - SCALING_FACTOR  1    divisor per axis; NUM_PIXELS = FRAME_WIDTH/SCALING_FACTOR*FRAME_HEIGHT/SCALING_FACTOR
// - ADDR_WIDTH      19   pixel address width; 2**ADDR_WIDTH >= NUM_PIXELS is an elaboration error otherwise
// - DATA_WIDTH      8    pixel width
// PORTS
// - clk           in   1           single clock, all logic posedge
// - rst           in   1           synchronous, active-high reset
// - req_valid     in   2           per-requester write request
// - req_addr      in   2*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - req_data      in   2*DATA_WIDTH  packed, same layout
// - req_ready     out  2           combinational grant; transfer when valid&ready
// - clear_start   in   1           one-cycle pulse starts a full-frame clear
// - clear_color   in   DATA_WIDTH  fill value, sampled on accepted clear_start
// - clear_busy    out  1           high while clear runs
// - clear_done    out  1           one-cycle pulse after the last clear write is issued
// - addr_err      out  1           one-cycle pulse: accepted request had addr >= NUM_PIXELS
// - fb_en_wr, fb_wrea  out 1       write strobes to framebuffer (always equal)
// - fb_addr_wr    out  ADDR_WIDTH  write address;  fb_din  out  DATA_WIDTH  write data
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, round-robin pointer = requester 0, clear counter 0.
// - FSM IDLE/ARB: at most one req_ready high per cycle; if both valid, grant pointer's requester;
//   if one valid, grant it. After a transfer, pointer moves to the other requester.
// - Latency: transfer in cycle N -> fb_en_wr=fb_wrea=1 with addr/data in cycle N+1. Back-to-back
//   transfers sustain one write per cycle. No transfer -> fb_en_wr=0 next cycle; addr/din hold.
// - Address check: addr >= NUM_PIXELS still completes handshake (ready honoured), but write is
//   suppressed (fb_en_wr=0) and addr_err pulses in cycle N+1.
// - FSM CLEAR: entered on clear_start in IDLE; req_ready=2'b00 throughout. Issues writes to
//   addresses 0..NUM_PIXELS-1 one per cycle, data=clear_color latched. First write in the cycle
//   after clear_start; clear_busy high from that cycle through the last write cycle; clear_done
//   pulses the cycle after last write; return to IDLE the same cycle clear_done is high.
// - clear_start while CLEAR: ignored. clear_start and req_valid same cycle in IDLE: clear wins,
//   no requester transfer that cycle. Round-robin pointer unchanged by a clear.
// - rst mid-clear: clear aborted, no clear_done, outputs 0 next cycle.
// CONFIGURATION
// - FB_ARB_CLEAR_EN defined: clear sequencer and CLEAR state compiled in as above.
// - Not defined: no sequencer; clear_start/clear_color ignored, clear_busy=clear_done=0 constant;
//   FSM reduces to round-robin arbitration only.
// STRUCTURE
// - Package fb_pkg: NUM_PIXELS computation helper, FSM state encoding (ST_IDLE, ST_CLEAR),
//   requester index constants; shared with the scanout side.
// - Sub-module fb_clear_seq: address counter + done pulse, instantiated only under FB_ARB_CLEAR_EN.
// TESTING
// - Both valid continuously, addr 10/20, data 8'hAA/8'h55: writes alternate 10,20,10,... one per
//   cycle, req 0 first after reset.
// - Single requester valid 4 cycles, addr 0..3: fb writes at cycles N+1..N+4, no gaps.
// - Requester 1 addr 307200 (NUM_PIXELS, default params): handshake completes, fb_en_wr=0,
//   addr_err=1 for one cycle.
// - clear_start, colour 8'h0F, defaults: 307200 writes addr 0..307199 data 8'h0F, req_ready=0
//   whole time, clear_done one pulse after addr 307199; SCALING_FACTOR=4 gives 19200 writes.
// - rst asserted at clear address 100: next cycle all outputs 0, no clear_done; requests serve
//   again with pointer = requester 0.
// - Build without FB_ARB_CLEAR_EN: clear_start pulse -> no writes, clear_busy/clear_done stay 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: pixel-count helper, write-arbiter FSM states, requester indices.
package fb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned REQ0    = 0;
    localparam int unsigned REQ1    = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_arb_state_e;

    // Evaluated left to right, matching the scanout side's pixel count.
    function automatic int unsigned num_pixels(input int unsigned width,
                                               input int unsigned height,
                                               input int unsigned scale);
        return (width / scale) * height / scale;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Framebuffer write-arbiter bus: requester handshakes, clear control and framebuffer write side.
interface fb_write_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [1:0]              req_valid;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_data;
    logic [1:0]              req_ready;
    logic                    clear_start;
    logic [DATA_WIDTH-1:0]   clear_color;
    logic                    clear_busy;
    logic                    clear_done;
    logic                    addr_err;
    logic                    fb_en_wr;
    logic                    fb_wrea;
    logic [ADDR_WIDTH-1:0]   fb_addr_wr;
    logic [DATA_WIDTH-1:0]   fb_din;

    modport master (
        output req_valid, req_addr, req_data, clear_start, clear_color,
        input  req_ready, clear_busy, clear_done, addr_err,
               fb_en_wr, fb_wrea, fb_addr_wr, fb_din
    );

    modport slave (
        input  req_valid, req_addr, req_data, clear_start, clear_color,
        output req_ready, clear_busy, clear_done, addr_err,
               fb_en_wr, fb_wrea, fb_addr_wr, fb_din
    );
endinterface

// File: rtl/fb_clear_seq.sv
// Full-frame clear sequencer: offers addresses 0..NUM_PIXELS-1 one per cycle and flags completion.
module fb_clear_seq #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PIXELS = 307200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] color_i,
    output logic                  issue_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  done_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    logic                  run_q, run_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  done_q, done_d;
    logic                  last;

    // The start cycle issues address 0 directly so the first write lands right after start.
    always_comb begin
        issue_o = start_i | run_q;
        addr_o  = run_q ? cnt_q : '0;
        data_o  = run_q ? color_q : color_i;
        last    = issue_o && (addr_o == LAST_ADDR);
        run_d   = issue_o && !last;
        cnt_d   = issue_o ? addr_o + ADDR_WIDTH'(1) : cnt_q;
        color_d = issue_o ? data_o : color_q;
        done_d  = last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer write port plus optional full-frame clear.
// The clear sequencer is compiled in only when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH    = 640,
    parameter int unsigned FRAME_HEIGHT   = 480,
    parameter int unsigned SCALING_FACTOR = 1,
    parameter int unsigned ADDR_WIDTH     = 19,
    parameter int unsigned DATA_WIDTH     = 8
) (
    input  logic              clk,
    input  logic              rst,
    fb_write_arbiter_if.slave bus
);
    localparam int unsigned NUM_PIXELS = num_pixels(FRAME_WIDTH, FRAME_HEIGHT, SCALING_FACTOR);
    localparam logic [ADDR_WIDTH:0] PIX_LIMIT = (ADDR_WIDTH + 1)'(NUM_PIXELS);

    if ((64'd1 << ADDR_WIDTH) < 64'(NUM_PIXELS)) begin : g_bad_addr_width
        $error("fb_write_arbiter: ADDR_WIDTH too small for NUM_PIXELS");
    end

    fb_arb_state_e state_q, state_d;
    logic          rr_q, rr_d;

    logic [NUM_REQ-1:0]    ready;
    logic                  grant_idx;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  clr_start;
    logic                  clr_issue;
    logic                  clr_done;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_data;

    logic                  fb_en_q, fb_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

`ifdef FB_ARB_CLEAR_EN
    assign clr_start = (state_q == ST_IDLE) && bus.clear_start;

    fb_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PIXELS (NUM_PIXELS)
    ) u_clear_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (clr_start),
        .color_i (bus.clear_color),
        .issue_o (clr_issue),
        .addr_o  (clr_addr),
        .data_o  (clr_data),
        .done_o  (clr_done)
    );
`else
    logic unused_clear;
    assign unused_clear = ^{bus.clear_start, bus.clear_color};
    assign clr_start    = 1'b0;
    assign clr_issue    = 1'b0;
    assign clr_done     = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= 1'(REQ0);
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clr_start) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_done)  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Grant goes to the pointer's requester when it is valid, otherwise to the other one.
    always_comb begin
        ready     = '0;
        grant_idx = rr_q;
        if (state_q == ST_IDLE && !clr_start) begin
            grant_idx        = bus.req_valid[rr_q] ? rr_q : ~rr_q;
            ready[grant_idx] = bus.req_valid[grant_idx];
        end
        xfer     = |(ready & bus.req_valid);
        sel_addr = (grant_idx == 1'(REQ1)) ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                            : bus.req_addr[0 +: ADDR_WIDTH];
        sel_data = (grant_idx == 1'(REQ1)) ? bus.req_data[DATA_WIDTH +: DATA_WIDTH]
                                            : bus.req_data[0 +: DATA_WIDTH];
        rr_d     = xfer ? ~grant_idx : rr_q;

        fb_en_d = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        err_d   = 1'b0;
        busy_d  = clr_issue;
        done_d  = clr_done;
        if (clr_issue) begin
            fb_en_d = 1'b1;
            addr_d  = clr_addr;
            din_d   = clr_data;
        end else if (xfer) begin
            if ({1'b0, sel_addr} >= PIX_LIMIT) begin
                err_d = 1'b1;
            end else begin
                fb_en_d = 1'b1;
                addr_d  = sel_addr;
                din_d   = sel_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_en_q <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fb_en_q <= fb_en_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.fb_en_wr   = fb_en_q;
    assign bus.fb_wrea    = fb_en_q;
    assign bus.fb_addr_wr = addr_q;
    assign bus.fb_din     = din_q;
    assign bus.addr_err   = err_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter at 640x480 / scale 4 (19200 pixels); clear checks follow FB_ARB_CLEAR_EN.
module tb_fb_write_arbiter;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 8;
    localparam int unsigned NP = 19200;
    localparam int unsigned VW = 7 + AW + DW;
`ifdef FB_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    fb_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fb_write_arbiter #(
        .FRAME_WIDTH    (640),
        .FRAME_HEIGHT   (480),
        .SCALING_FACTOR (4),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model: what the write port shows now, and whose turn it is.
    int            m_rr;
    bit            m_clr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din;

    logic [VW-1:0] obs_vec;
    logic [VW-1:0] exp_vec;

    task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic cs, input logic [DW-1:0] cc);
        bus.req_valid   = v;
        bus.req_addr    = {a1, a0};
        bus.req_data    = {d1, d0};
        bus.clear_start = cs;
        bus.clear_color = cc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(2'b00, '0, '0, '0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_rr   = 0;
        m_clr  = 1'b0;
        m_addr = '0;
        m_din  = '0;
        obs_vec = {bus.req_ready, bus.fb_en_wr, bus.fb_wrea, bus.addr_err, bus.clear_busy,
                   bus.clear_done, bus.fb_addr_wr, bus.fb_din};
        exp_vec = '0;
    endtask

    // One clock of stimulus; leaves observed and predicted vectors for the caller to compare.
    task automatic step(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic cs, input logic [DW-1:0] cc);
        int            win;
        logic [1:0]    obs_ready;
        logic [1:0]    exp_ready;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            n_en, n_err, n_busy, n_done;
        drive(v, a0, a1, d0, d1, cs, cc);
        #1;
        obs_ready = bus.req_ready;
        exp_ready = 2'b00;
        n_en = 0; n_err = 0; n_busy = 0; n_done = 0;
        if (m_clr) begin
            if (int'(m_addr) < NP - 1) begin
                n_en = 1; n_busy = 1;
                m_addr = m_addr + 1'b1;
            end else begin
                n_done = 1;
            end
        end else if (CLR_EN && cs) begin
            n_en = 1; n_busy = 1;
            m_addr = '0;
            m_din  = cc;
        end else begin
            win = -1;
            if (v[m_rr]) win = m_rr;
            else if (v[1 - m_rr]) win = 1 - m_rr;
            if (win >= 0) begin
                exp_ready[win] = 1'b1;
                m_rr = 1 - win;
                wa = (win == 1) ? a1 : a0;
                wd = (win == 1) ? d1 : d0;
                if (int'(wa) >= NP) begin
                    n_err = 1;
                end else begin
                    n_en = 1;
                    m_addr = wa;
                    m_din  = wd;
                end
            end
        end
        @(posedge clk);
        #1;
        m_clr = n_busy;
        obs_vec = {obs_ready, bus.fb_en_wr, bus.fb_wrea, bus.addr_err, bus.clear_busy,
                   bus.clear_done, bus.fb_addr_wr, bus.fb_din};
        exp_vec = {exp_ready, n_en, n_en, n_err, n_busy, n_done, m_addr, m_din};
        if (!n_en) begin
            obs_vec[AW+DW-1:0] = '0;
            exp_vec[AW+DW-1:0] = '0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 8; i++) begin
            step(2'b11, AW'(10), AW'(20), 8'hAA, 8'h55, 1'b0, '0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL round_robin[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_burst();
        for (int i = 0; i < 5; i++) begin
            step((i < 4) ? 2'b10 : 2'b00, '0, AW'(i), '0, DW'(8'h30 + i), 1'b0, '0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL single_burst[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_addr_err();
        for (int i = 0; i < 3; i++) begin
            step((i == 0) ? 2'b10 : 2'b00, AW'(5), AW'(NP), 8'h11, 8'h22, 1'b0, '0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL addr_err[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a[2];
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < 2; r++)
                a[r] = ($urandom_range(0, 7) == 0) ? AW'(NP + $urandom_range(0, 1000))
                                                   : AW'($urandom_range(0, NP - 1));
            step(2'($urandom), a[0], a[1], DW'($urandom), DW'($urandom), 1'b0, '0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_clear();
        int writes;
        int cycles;
        writes = 0;
        cycles = CLR_EN ? NP + 4 : 20;
        for (int i = 0; i < cycles; i++) begin
            step(2'($urandom), AW'($urandom_range(0, NP - 1)), AW'($urandom_range(0, NP - 1)),
                 DW'($urandom), DW'($urandom),
                 (i == 0) || (i < NP - 10 && $urandom_range(0, 15) == 0), 8'h0F);
            if (i < NP && bus.fb_en_wr === 1'b1 && bus.clear_busy === 1'b1) writes++;
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL clear[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (writes != (CLR_EN ? NP : 0)) begin
            miscompares++;
            $display("FAIL clear_count: got %0d writes want %0d", writes, CLR_EN ? NP : 0);
        end
    endtask

    task automatic test_clear_abort();
        for (int i = 0; i <= 100; i++) begin
            step(2'b00, '0, '0, '0, '0, i == 0, 8'hC3);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL abort_run[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
        do_reset();
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL abort_reset: got %h want %h", obs_vec, exp_vec);
        end
        for (int i = 0; i < 6; i++) begin
            step((i < 3) ? 2'b11 : 2'b00, AW'(5), AW'(6), 8'h01, 8'h02, 1'b0, '0);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL abort_after[%0d]: got %h want %h", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        drive(2'b00, '0, '0, '0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single_burst();
        test_addr_err();
        test_random();
        test_clear();
        test_random();
        test_clear_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
